// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator-machine control sequencer:
// opcodes, bus sources, AC/E operations and T-state values.
package ctrl_pkg;

    typedef enum logic [2:0] {
        D_AND = 3'd0,
        D_ADD = 3'd1,
        D_LDA = 3'd2,
        D_STA = 3'd3,
        D_BUN = 3'd4,
        D_BSA = 3'd5,
        D_ISZ = 3'd6,
        D_IO  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [3:0] {
        AC_NOP = 4'd0,
        AC_AND = 4'd1,
        AC_ADD = 4'd2,
        AC_LDA = 4'd3,
        AC_CLA = 4'd4,
        AC_CLE = 4'd5,
        AC_CMA = 4'd6,
        AC_CME = 4'd7,
        AC_CIR = 4'd8,
        AC_CIL = 4'd9,
        AC_INC = 4'd10
    } ac_op_e;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;

    // b = IR[11:5]; IR[11] (CLA) has the highest priority, IR[5] (INC) the lowest.
    function automatic ac_op_e rr_ac_op(input logic [6:0] b);
        ac_op_e op;
        if      (b[6]) op = AC_CLA;
        else if (b[5]) op = AC_CLE;
        else if (b[4]) op = AC_CMA;
        else if (b[3]) op = AC_CME;
        else if (b[2]) op = AC_CIR;
        else if (b[1]) op = AC_CIL;
        else if (b[0]) op = AC_INC;
        else           op = AC_NOP;
        return op;
    endfunction

endpackage

// File: rtl/ctrl_seq_counter.sv
// Sequence counter and run flag: clears, increments or holds sc; halt and
// start control the run flag.
module ctrl_seq_counter
    import ctrl_pkg::*;
#(
    parameter int unsigned SC_W = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_clr,
    input  logic            i_halt,
    output logic [SC_W-1:0] o_sc,
    output logic            o_run
);

    logic [SC_W-1:0] r_sc;
    logic            r_run;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sc  <= '0;
            r_run <= 1'b1;
        end else if (!r_run) begin
            r_sc <= '0;
            if (i_start) begin
                r_run <= 1'b1;
            end
        end else begin
            if (i_halt) begin
                r_run <= 1'b0;
            end
            // Anything at or past T6 wraps so an illegal count cannot persist.
            if (i_clr || (r_sc >= SC_W'(T6))) begin
                r_sc <= '0;
            end else begin
                r_sc <= r_sc + SC_W'(1);
            end
        end
    end

    assign o_sc  = r_sc;
    assign o_run = r_run;

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer: decodes (sc, run, IR) into PC, register,
// memory, bus and AC strobes for the 16-bit accumulator machine.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned SC_W = 3
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            start,
    input  logic [15:0]     IR,
    output logic [SC_W-1:0] sc,
    output logic            run,
    output logic            pcCLR,
    output logic            pcLD,
    output logic            pcINR,
    output logic            ISZ,
    output logic            SPA,
    output logic            SNA,
    output logic            SZA,
    output logic            SZE,
    output logic            arLD,
    output logic            arINR,
    output logic            irLD,
    output logic            drLD,
    output logic            drINR,
    output logic            memRD,
    output logic            memWR,
    output logic [2:0]      busSel,
    output logic [3:0]      acOp
);

    logic [SC_W-1:0] w_sc;
    logic            w_run;
    logic            w_clr;
    logic            w_halt;
    logic            w_i;
    opcode_e         w_d;
    logic [11:0]     w_b;
    bus_sel_e        w_bus_sel;
    ac_op_e          w_ac_op;

    assign w_i = IR[15];
    assign w_d = opcode_e'(IR[14:12]);
    assign w_b = IR[11:0];

    ctrl_seq_counter #(
        .SC_W (SC_W)
    ) u_counter (
        .i_clk   (CLK),
        .i_rst_n (RSTn),
        .i_start (start),
        .i_clr   (w_clr),
        .i_halt  (w_halt),
        .o_sc    (w_sc),
        .o_run   (w_run)
    );

    always_comb begin
        pcCLR     = 1'b0;
        pcLD      = 1'b0;
        pcINR     = 1'b0;
        ISZ       = 1'b0;
        SPA       = 1'b0;
        SNA       = 1'b0;
        SZA       = 1'b0;
        SZE       = 1'b0;
        arLD      = 1'b0;
        arINR     = 1'b0;
        irLD      = 1'b0;
        drLD      = 1'b0;
        drINR     = 1'b0;
        memRD     = 1'b0;
        memWR     = 1'b0;
        w_bus_sel = BUS_NONE;
        w_ac_op   = AC_NOP;
        w_clr     = 1'b0;
        w_halt    = 1'b0;
        if (!RSTn) begin
            pcCLR = 1'b1;
        end else if (w_run) begin
            case (w_sc)
                SC_W'(T0): begin
                    w_bus_sel = BUS_PC;
                    arLD      = 1'b1;
                end
                SC_W'(T1): begin
                    w_bus_sel = BUS_MEM;
                    memRD     = 1'b1;
                    irLD      = 1'b1;
                    pcINR     = 1'b1;
                end
                SC_W'(T2): begin
                    w_bus_sel = BUS_IR;
                    arLD      = 1'b1;
                end
                SC_W'(T3): begin
                    if (w_d == D_IO) begin
                        w_clr = 1'b1;
                        if (!w_i) begin
                            SPA     = w_b[4];
                            SNA     = w_b[3];
                            SZA     = w_b[2];
                            SZE     = w_b[1];
                            w_ac_op = rr_ac_op(w_b[11:5]);
                            w_halt  = w_b[0];
                        end
                    end else if (w_i) begin
                        w_bus_sel = BUS_MEM;
                        memRD     = 1'b1;
                        arLD      = 1'b1;
                    end
                end
                SC_W'(T4): begin
                    case (w_d)
                        D_AND, D_ADD, D_LDA, D_ISZ: begin
                            w_bus_sel = BUS_MEM;
                            memRD     = 1'b1;
                            drLD      = 1'b1;
                        end
                        D_STA: begin
                            w_bus_sel = BUS_AC;
                            memWR     = 1'b1;
                            w_clr     = 1'b1;
                        end
                        D_BUN: begin
                            w_bus_sel = BUS_AR;
                            pcLD      = 1'b1;
                            w_clr     = 1'b1;
                        end
                        D_BSA: begin
                            w_bus_sel = BUS_PC;
                            memWR     = 1'b1;
                            arINR     = 1'b1;
                        end
                        default: w_clr = 1'b1;
                    endcase
                end
                SC_W'(T5): begin
                    w_clr = 1'b1;
                    case (w_d)
                        D_AND: w_ac_op = AC_AND;
                        D_ADD: w_ac_op = AC_ADD;
                        D_LDA: w_ac_op = AC_LDA;
                        D_BSA: begin
                            w_bus_sel = BUS_AR;
                            pcLD      = 1'b1;
                        end
                        D_ISZ: begin
                            drINR = 1'b1;
                            w_clr = 1'b0;
                        end
                        default: w_clr = 1'b1;
                    endcase
                end
                SC_W'(T6): begin
                    w_clr = 1'b1;
                    if (w_d == D_ISZ) begin
                        w_bus_sel = BUS_DR;
                        memWR     = 1'b1;
                        ISZ       = 1'b1;
                    end
                end
                default: w_clr = 1'b1;
            endcase
        end
    end

    assign sc     = w_sc;
    assign run    = w_run;
    assign busSel = w_bus_sel;
    assign acOp   = w_ac_op;

endmodule
